// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO pointer/flag controller.
package fifo_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } op_t;

    function automatic int unsigned depth_of(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping storage pointer: advances by one on inc_i, rolls over DEPTH-1 -> 0.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc_i,
    output logic [ADDR_WIDTH-1:0] ptr_o
);

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// First-word-fall-through FIFO controller for an external dual-port register file:
// owns head/tail pointers, occupancy count, status flags and error pulses.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_LEVEL   = 6,
    parameter int unsigned AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned         Depth    = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DepthCnt = Depth[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AfCnt    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AeCnt    = AE_LEVEL[ADDR_WIDTH:0];

    logic                push;
    logic                pop;
    op_t                 op;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                full_q, empty_q, af_q, ae_q, ovf_q, udf_q;

    // A full FIFO still accepts a write when the same edge frees a slot.
    assign push = wr & (~full_q | rd);
    assign pop  = rd & ~empty_q;
    assign op   = op_t'({push, pop});

    always_comb begin
        count_d = count_q;
        unique case (op)
            OP_PUSH: count_d = count_q + 1'b1;
            OP_POP:  count_d = count_q - 1'b1;
            OP_NOP:  count_d = count_q;
            OP_BOTH: count_d = count_q;
            default: count_d = count_q;
        endcase
    end

    // Flags come from next-count so they line up with count itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == DepthCnt);
            empty_q <= (count_d == '0);
            af_q    <= (count_d >= AfCnt);
            ae_q    <= (count_d <= AeCnt);
            ovf_q   <= wr & ~push;
            udf_q   <= rd & ~pop;
        end
    end

    fifo_ptr #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_tail (
        .clk  (clk),
        .reset(reset),
        .inc_i(push),
        .ptr_o(w_addr)
    );

    fifo_ptr #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_head (
        .clk  (clk),
        .reset(reset),
        .inc_i(pop),
        .ptr_o(r_addr)
    );

    assign w_en         = push;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // Pointer distance equals count modulo DEPTH; a full FIFO shows distance zero.
    a_count_ptr: assert property (@(posedge clk) disable iff (reset)
        count_q[ADDR_WIDTH-1:0] == ADDR_WIDTH'(w_addr - r_addr));
    a_full_cnt: assert property (@(posedge clk) disable iff (reset)
        full_q == (count_q == DepthCnt));
    a_not_both: assert property (@(posedge clk) disable iff (reset)
        !(full_q && empty_q));
    a_no_wr_full: assert property (@(posedge clk) disable iff (reset)
        (full_q && !rd) |-> !w_en);

endmodule
